// File: rtl/grid_scan.sv
// Raster scanner: snapshots a cell bitmap on frame_tick and streams one cell per
// valid/ready handshake. Optional macro GRID_SCAN_OVERRUN_CNT_EN adds overrun_cnt.
module grid_scan #(
    parameter int unsigned COLS = 8,
    parameter int unsigned ROWS = 18,
    localparam int unsigned NCELL = COLS * ROWS,
    localparam int unsigned XW = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int unsigned YW = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int unsigned IW = ($clog2(NCELL) > 8) ? $clog2(NCELL) : 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_tick,
    input  logic [NCELL-1:0] data_updated,
    output logic             cell_valid,
    input  logic             cell_ready,
    output logic [XW-1:0]    cell_x,
    output logic [YW-1:0]    cell_y,
    output logic             cell_on,
    output logic             draw_finish,
    output logic             busy
`ifdef GRID_SCAN_OVERRUN_CNT_EN
    ,
    output logic [7:0]       overrun_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

    state_e           state_q, state_d;
    logic [XW-1:0]    x_q, x_d;
    logic [YW-1:0]    y_q, y_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [NCELL-1:0] snap_q, snap_d;
    logic             valid_q, valid_d;
    logic             on_q, on_d;
    logic             fin_q, fin_d;
    logic             busy_q, busy_d;
    logic             accept;
    logic [IW-1:0]    nxt_idx;

    assign accept  = valid_q & cell_ready;
    assign nxt_idx = idx_q + 1'b1;

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        valid_d = valid_q;
        on_d    = on_q;
        fin_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_tick) begin
                    snap_d  = data_updated;
                    x_d     = '0;
                    y_d     = '0;
                    idx_d   = '0;
                    valid_d = 1'b1;
                    on_d    = data_updated[0];
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (accept) begin
                    if (idx_q == IW'(NCELL - 1)) begin
                        valid_d = 1'b0;
                        on_d    = 1'b0;
                        fin_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        idx_d = nxt_idx;
                        on_d  = snap_q[nxt_idx];
                        if (x_q == XW'(COLS - 1)) begin
                            x_d = '0;
                            y_d = y_q + 1'b1;
                        end else begin
                            x_d = x_q + 1'b1;
                        end
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            idx_q   <= '0;
            snap_q  <= '0;
            valid_q <= 1'b0;
            on_q    <= 1'b0;
            fin_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            valid_q <= valid_d;
            on_q    <= on_d;
            fin_q   <= fin_d;
            busy_q  <= busy_d;
        end
    end

    assign cell_valid  = valid_q;
    assign cell_x      = x_q;
    assign cell_y      = y_q;
    assign cell_on     = on_q;
    assign draw_finish = fin_q;
    assign busy        = busy_q;

`ifdef GRID_SCAN_OVERRUN_CNT_EN
    // Ticks arriving while a frame is in flight are dropped and counted
    logic [7:0] ovr_q, ovr_d;

    always_comb begin
        ovr_d = ovr_q;
        if (frame_tick && (state_q != IDLE) && (ovr_q != 8'hFF)) begin
            ovr_d = ovr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr_q <= '0;
        end else begin
            ovr_q <= ovr_d;
        end
    end

    assign overrun_cnt = ovr_q;
`endif

endmodule
